// File: rtl/cube_scan_driver.sv
// cube_scan_driver: autonomous scan engine for an 8x8x8 LED cube.
// Reads a 64-byte frame buffer one row at a time and loads the eight column latches.
// After a layer is loaded it lights that layer for ON_CYCLES.
// Each layer is preceded by BLANK_CYCLES of all-layers-off time to prevent ghosting.
// Ports:
//   clk, reset (async, active-high), enable (run when high)
//   rd_addr  -> frame-buffer address {layer,row}; rd_data <- 1-cycle synchronous read data
//   layers   -> one-hot layer enable; latches -> column-latch enables (bit = row)
//   data     -> column data bus; frame_done -> pulse on last SHOW cycle of layer 7
module cube_scan_driver #(
  parameter int unsigned ON_CYCLES    = 6250,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [5:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] layers,
  output logic [7:0] latches,
  output logic [7:0] data,
  output logic       frame_done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BLANK, S_FETCH, S_WAIT, S_SETUP, S_LATCH, S_HOLD, S_SHOW
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       rd_addr_q, rd_addr_d;
  logic [7:0]       layers_q, layers_d;
  logic [7:0]       latches_q, latches_d;
  logic [7:0]       data_q, data_d;
  logic             frame_done_q, frame_done_d;

  // Next-state, counters and next output values.
  // Outputs are derived from the next state so they are registered yet aligned with the state.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    row_d        = row_q;
    cnt_d        = cnt_q + CNT_W'(1);
    data_d       = data_q;
    rd_addr_d    = rd_addr_q;
    layers_d     = '0;
    latches_d    = '0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_BLANK;
          layer_d = '0;
          row_d   = '0;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // Read data for the address issued in FETCH is valid now.
        state_d = S_SETUP;
        cnt_d   = '0;
        data_d  = rd_data;
      end
      S_SETUP: begin
        state_d = S_LATCH;
        cnt_d   = '0;
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (row_q == 3'd7) begin
          row_d   = '0;
          state_d = S_SHOW;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = S_FETCH;
        end
      end
      S_SHOW: begin
        if (cnt_q == ON_LAST) begin
          layer_d = layer_q + 3'd1;
          state_d = S_BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable abandons the scan from any state.
    if (!enable) begin
      state_d = S_IDLE;
      layer_d = '0;
      row_d   = '0;
      cnt_d   = '0;
      data_d  = '0;
    end

    if (state_d == S_FETCH) begin
      rd_addr_d = {layer_d, row_d};
    end else if (state_d == S_IDLE) begin
      rd_addr_d = '0;
    end

    if (state_d == S_SHOW) begin
      layers_d     = 8'(8'd1 << layer_d);
      frame_done_d = (layer_d == 3'd7) && (cnt_d == ON_LAST);
    end

    if (state_d == S_LATCH) begin
      latches_d = 8'(8'd1 << row_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      rd_addr_q    <= '0;
      layers_q     <= '0;
      latches_q    <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      layers_q     <= layers_d;
      latches_q    <= latches_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign layers     = layers_q;
  assign latches    = latches_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;

endmodule
